// File: rtl/fruit_motion.sv
// -----------------------------------------------------------------------------
// fruit_motion
//
// Motion engine for a single fruit on the fruit-ninja display path. Once per
// video frame it either counts down the respawn delay, or integrates the fruit's
// parabolic flight. It launches each fruit from the bottom edge with a
// pseudo-random position and velocity. It detects slices from the USB keycode
// and keeps a saturating score.
//
// Ports:
//   Clk           in   50 MHz system clock
//   Reset_n       in   asynchronous active-low reset
//   vs            in   VGA vertical sync (active low, asynchronous)
//   keycode[7:0]  in   current USB keycode, 0 = no key
//   fruitX[9:0]   out  fruit centre X
//   fruitY[9:0]   out  fruit centre Y
//   fruitS[9:0]   out  fruit radius (constant FRUIT_SIZE)
//   fruit_active  out  fruit visible (in flight)
//   sliced_pulse  out  one-clock pulse per accepted slice
//   missed_pulse  out  one-clock pulse when the fruit falls out unsliced
//   score[7:0]    out  slice count, saturating at 255
//
// Build option:
//   FRUIT_WALL_BOUNCE_EN  when defined, a wall hit negates vx and holds X;
//                         otherwise X clamps to the wall and vx becomes 0.
// -----------------------------------------------------------------------------
module fruit_motion #(
  parameter int          SCREEN_W       = 640,
  parameter int          SCREEN_H       = 480,
  parameter int          FRUIT_SIZE     = 16,
  parameter int          GRAVITY        = 1,
  parameter int          RESPAWN_FRAMES = 60,
  parameter logic [7:0]  SLICE_KEY      = 8'h2C,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       vs,
  input  logic [7:0] keycode,
  output logic [9:0] fruitX,
  output logic [9:0] fruitY,
  output logic [9:0] fruitS,
  output logic       fruit_active,
  output logic       sliced_pulse,
  output logic       missed_pulse,
  output logic [7:0] score
);

  localparam int                 CNT_W    = (RESPAWN_FRAMES > 1) ? $clog2(RESPAWN_FRAMES) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(RESPAWN_FRAMES - 1);
  localparam logic signed [11:0] X_LO     = 12'(FRUIT_SIZE);
  localparam logic signed [11:0] X_HI     = 12'(SCREEN_W - 1 - FRUIT_SIZE);
  localparam logic signed [10:0] Y_LIMIT  = 11'(SCREEN_H);
  localparam logic signed [8:0]  GRAV     = 9'(GRAVITY);
  localparam logic [9:0]         X_RESET  = 10'(SCREEN_W / 2);
  localparam logic [9:0]         Y_START  = 10'(SCREEN_H - 1);

  typedef enum logic [1:0] {
    ST_WAIT,
    ST_LAUNCH,
    ST_FLYING
  } state_t;

  state_t state, state_nxt;

  // Frame tick: two synchronizer flops, then a registered falling-edge detect.
  // The chain resets to the idle-high level so releasing reset cannot fake a tick.
  logic vs_meta, vs_sync, vs_prev, tick;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      vs_meta <= 1'b1;
      vs_sync <= 1'b1;
      vs_prev <= 1'b1;
      tick    <= 1'b0;
    end else begin
      vs_meta <= vs;
      vs_sync <= vs_meta;
      vs_prev <= vs_sync;
      tick    <= vs_prev & ~vs_sync;
    end
  end

  // Slice is the first clock of a SLICE_KEY press, so a held key slices once.
  logic [7:0] key_prev;
  logic       slice_evt;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) key_prev <= 8'h00;
    else          key_prev <= keycode;
  end

  assign slice_evt = (keycode == SLICE_KEY) && (key_prev != SLICE_KEY);

  // Right-shifting Galois LFSR for x^16+x^14+x^13+x^11. The feedback bit
  // (old bit 0) enters at bit 15 and is folded into bits 13, 12 and 10.
  logic [15:0] lfsr, lfsr_step;

  always_comb begin
    lfsr_step = {lfsr[0], lfsr[15], lfsr[14] ^ lfsr[0], lfsr[13] ^ lfsr[0],
                 lfsr[12], lfsr[11] ^ lfsr[0], lfsr[10:1]};
  end

  // Motion state. fruitX/fruitY are the position registers themselves.
  logic [CNT_W-1:0]  frame_cnt, frame_cnt_nxt;
  logic signed [7:0] vx, vx_nxt;
  logic signed [7:0] vy, vy_nxt;
  logic [9:0]        x_nxt, y_nxt;
  logic [7:0]        score_nxt;
  logic              sliced_nxt, missed_nxt, active_nxt;

  // Candidate positions for this frame, widened and signed so that wall and
  // floor comparisons see the true value before any clamping.
  logic signed [11:0] x_sum;
  logic signed [10:0] y_sum;
  logic signed [8:0]  vy_sum;
  logic               wall_lo, wall_hi, miss;

  always_comb begin
    x_sum   = $signed({2'b00, fruitX}) + $signed({{4{vx[7]}}, vx});
    y_sum   = $signed({1'b0, fruitY}) + $signed({{3{vy[7]}}, vy});
    vy_sum  = $signed({vy[7], vy}) + GRAV;
    wall_lo = (x_sum < X_LO);
    wall_hi = (x_sum > X_HI);
    miss    = (vy > 8'sd0) && (y_sum >= Y_LIMIT);
  end

  // Next-state and next-value logic. Slice takes priority over the frame
  // update, so a slice landing on the miss tick never reports a miss.
  always_comb begin
    state_nxt     = state;
    frame_cnt_nxt = frame_cnt;
    x_nxt         = fruitX;
    y_nxt         = fruitY;
    vx_nxt        = vx;
    vy_nxt        = vy;
    score_nxt     = score;
    sliced_nxt    = 1'b0;
    missed_nxt    = 1'b0;

    case (state)
      ST_WAIT: begin
        if (tick) begin
          if (frame_cnt == CNT_LAST) begin
            frame_cnt_nxt = '0;
            state_nxt     = ST_LAUNCH;
          end else begin
            frame_cnt_nxt = frame_cnt + 1'b1;
          end
        end
      end

      ST_LAUNCH: begin
        x_nxt     = 10'd64 + {1'b0, lfsr[8:0]};
        y_nxt     = Y_START;
        vy_nxt    = 8'd0 - (8'd12 + {4'd0, lfsr[12:9]});
        vx_nxt    = {5'd0, lfsr[15:13]} - 8'd4;
        state_nxt = ST_FLYING;
      end

      ST_FLYING: begin
        if (slice_evt) begin
          sliced_nxt    = 1'b1;
          score_nxt     = (score == 8'hFF) ? score : score + 8'd1;
          frame_cnt_nxt = '0;
          state_nxt     = ST_WAIT;
        end else if (tick) begin
          if (miss) begin
            // Position is left at its last on-screen value.
            missed_nxt    = 1'b1;
            frame_cnt_nxt = '0;
            state_nxt     = ST_WAIT;
          end else begin
            y_nxt = (y_sum < 11'sd0) ? 10'd0 : y_sum[9:0];

            if (vy_sum > 9'sd127)       vy_nxt = 8'sd127;
            else if (vy_sum < -9'sd128) vy_nxt = -8'sd128;
            else                        vy_nxt = vy_sum[7:0];

            if (wall_lo || wall_hi) begin
`ifdef FRUIT_WALL_BOUNCE_EN
              vx_nxt = 8'd0 - vx;
`else
              x_nxt  = wall_lo ? X_LO[9:0] : X_HI[9:0];
              vx_nxt = 8'sd0;
`endif
            end else begin
              x_nxt = x_sum[9:0];
            end
          end
        end
      end

      default: begin
        state_nxt = ST_WAIT;
      end
    endcase

    active_nxt = (state_nxt == ST_FLYING);
  end

  // All state and outputs are registered here.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state        <= ST_WAIT;
      frame_cnt    <= '0;
      fruitX       <= X_RESET;
      fruitY       <= Y_START;
      vx           <= 8'sd0;
      vy           <= 8'sd0;
      score        <= 8'd0;
      fruit_active <= 1'b0;
      sliced_pulse <= 1'b0;
      missed_pulse <= 1'b0;
      lfsr         <= LFSR_SEED;
    end else begin
      state        <= state_nxt;
      frame_cnt    <= frame_cnt_nxt;
      fruitX       <= x_nxt;
      fruitY       <= y_nxt;
      vx           <= vx_nxt;
      vy           <= vy_nxt;
      score        <= score_nxt;
      fruit_active <= active_nxt;
      sliced_pulse <= sliced_nxt;
      missed_pulse <= missed_nxt;
      if (tick) lfsr <= lfsr_step;
    end
  end

  assign fruitS = 10'(FRUIT_SIZE);

endmodule
